// File: rtl/quant_pkg.sv
// Shared quantisation constants for the requant/bound stage and the ReLU block.
// Both blocks take BO_BW from here so the bounded word width cannot drift apart.
package quant_pkg;

    localparam int ACC_BW_DEF = 24;
    localparam int BO_BW_DEF  = 8;
    localparam int SH_BW_DEF  = 5;
    localparam int CNT_BW_DEF = 16;

    localparam int BO_MAX = (2 ** (BO_BW_DEF - 1)) - 1;
    localparam int BO_MIN = -(2 ** (BO_BW_DEF - 1));

    // Shifting by ACC_BW or more would discard the sign, so cap at ACC_BW-1.
    function automatic int clamp_shift(input int sh, input int acc_bw);
        return (sh > acc_bw - 1) ? (acc_bw - 1) : sh;
    endfunction

endpackage

// File: rtl/bound_round_shift.sv
// Combinational clamp + round-half-toward-+inf + arithmetic right shift.
// One guard bit above the accumulator keeps the rounding add from overflowing.
module bound_round_shift
    import quant_pkg::*;
#(
    parameter int ACC_BW = ACC_BW_DEF,
    parameter int SH_BW  = SH_BW_DEF
) (
    input  logic signed [ACC_BW-1:0] i_acc,
    input  logic        [SH_BW-1:0]  i_shift,
    output logic signed [ACC_BW-1:0] o_data
);

    logic        [SH_BW-1:0] w_sh;
    logic signed [ACC_BW:0]  w_ext;
    logic signed [ACC_BW:0]  w_rnd;
    logic signed [ACC_BW:0]  w_sum;
    logic signed [ACC_BW:0]  w_shr;

    always_comb begin
        w_sh  = SH_BW'(clamp_shift(int'(i_shift), ACC_BW));
        w_ext = {i_acc[ACC_BW-1], i_acc};
        w_rnd = '0;
        if (w_sh != '0) begin
            w_rnd = (ACC_BW + 1)'(1) << (w_sh - SH_BW'(1));
        end
        w_sum = w_ext + w_rnd;
        w_shr = w_sum >>> w_sh;
        // After a shift of at least one the result always fits back in ACC_BW.
        o_data = (w_sh == '0) ? i_acc : ACC_BW'(w_shr);
    end

endmodule

// File: rtl/bound_requant.sv
// Two-stage requantiser: round-shift into s1, saturate to BO_BW into the output
// register, valid/ready on both sides, sticky saturation counter for the host.
module bound_requant
    import quant_pkg::*;
#(
    parameter int ACC_BW = ACC_BW_DEF,
    parameter int BO_BW  = BO_BW_DEF,
    parameter int SH_BW  = SH_BW_DEF,
    parameter int CNT_BW = CNT_BW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ACC_BW-1:0] i_acc_data,
    input  logic [SH_BW-1:0]  i_shift,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BO_BW-1:0]  o_bound_data,
    output logic [CNT_BW-1:0] o_sat_cnt,
    input  logic              i_sat_clr
);

    localparam int SAT_HI_I = (2 ** (BO_BW - 1)) - 1;
    localparam int SAT_LO_I = -(2 ** (BO_BW - 1));
    localparam logic signed [ACC_BW-1:0] SAT_HI = ACC_BW'(SAT_HI_I);
    localparam logic signed [ACC_BW-1:0] SAT_LO = ACC_BW'(SAT_LO_I);

    logic                     r_s1_valid;
    logic signed [ACC_BW-1:0] r_s1_data;
    logic                     r_out_valid;
    logic        [BO_BW-1:0]  r_bound_data;
    logic                     r_sat;
    logic        [CNT_BW-1:0] r_sat_cnt;

    logic                     w_en1;
    logic                     w_en2;
    logic signed [ACC_BW-1:0] w_shifted;
    logic        [BO_BW-1:0]  w_sat_data;
    logic                     w_sat;
    logic                     w_out_xfer;

    bound_round_shift #(
        .ACC_BW (ACC_BW),
        .SH_BW  (SH_BW)
    ) u_round_shift (
        .i_acc   ($signed(i_acc_data)),
        .i_shift (i_shift),
        .o_data  (w_shifted)
    );

    // No skid buffer: upstream ready follows downstream ready combinationally.
    assign w_en2      = !r_out_valid || i_ready;
    assign w_en1      = !r_s1_valid || w_en2;
    assign w_out_xfer = r_out_valid && i_ready;

    always_comb begin
        w_sat      = 1'b0;
        w_sat_data = r_s1_data[BO_BW-1:0];
        if (r_s1_data > SAT_HI) begin
            w_sat      = 1'b1;
            w_sat_data = BO_BW'(SAT_HI_I);
        end else if (r_s1_data < SAT_LO) begin
            w_sat      = 1'b1;
            w_sat_data = BO_BW'(SAT_LO_I);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_out_valid  <= 1'b0;
            r_bound_data <= '0;
            r_sat        <= 1'b0;
            r_sat_cnt    <= '0;
        end else begin
            if (w_en1) begin
                r_s1_valid <= i_valid;
                if (i_valid) begin
                    r_s1_data <= w_shifted;
                end
            end
            if (w_en2) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_bound_data <= w_sat_data;
                    r_sat        <= w_sat;
                end
            end
            // Clear wins over a same-cycle increment; the count saturates at all-ones.
            if (i_sat_clr) begin
                r_sat_cnt <= '0;
            end else if (w_out_xfer && r_sat && (r_sat_cnt != '1)) begin
                r_sat_cnt <= r_sat_cnt + CNT_BW'(1);
            end
        end
    end

    assign o_ready      = w_en1;
    assign o_valid      = r_out_valid;
    assign o_bound_data = r_bound_data;
    assign o_sat_cnt    = r_sat_cnt;

endmodule

// File: tb/tb_bound_requant.sv
// Scoreboard bench for bound_requant: driver pushes model results, monitor pops
// and compares on each output transfer and tracks the saturation counters.
module tb_bound_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic        i_sat_clr;
    logic [23:0] i_acc_data;
    logic [4:0]  i_shift;

    logic        o_ready,  o_valid;
    logic [7:0]  o_bound_data;
    logic [15:0] o_sat_cnt;
    logic        o_ready4, o_valid4;
    logic [7:0]  o_bound_data4;
    logic [3:0]  o_sat_cnt4;

    typedef struct packed {
        logic [7:0] data;
        logic       sat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b0;
    bit   rnd_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bound_requant dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_acc_data(i_acc_data), .i_shift(i_shift), .o_valid(o_valid),
        .i_ready(i_ready), .o_bound_data(o_bound_data), .o_sat_cnt(o_sat_cnt),
        .i_sat_clr(i_sat_clr)
    );

    bound_requant #(.CNT_BW(4)) dut4 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready4),
        .i_acc_data(i_acc_data), .i_shift(i_shift), .o_valid(o_valid4),
        .i_ready(i_ready), .o_bound_data(o_bound_data4), .o_sat_cnt(o_sat_cnt4),
        .i_sat_clr(i_sat_clr)
    );

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: exact integer floor((acc + 2^(sh-1)) / 2^sh), then clip to int8.
    function automatic exp_t model(input logic [23:0] acc_bits, input logic [4:0] sh_bits);
        exp_t   r;
        longint a;
        longint v;
        longint num;
        longint d;
        int     sh;
        a  = longint'($signed(acc_bits));
        sh = int'(sh_bits);
        if (sh > 23) sh = 23;
        if (sh == 0) begin
            v = a;
        end else begin
            num = a + (longint'(1) << (sh - 1));
            d   = longint'(1) << sh;
            v   = num / d;
            if ((num % d != 0) && (num < 0)) v = v - 1;
        end
        r.sat = 1'b0;
        if (v > 127) begin
            v = 127;  r.sat = 1'b1;
        end else if (v < -128) begin
            v = -128; r.sat = 1'b1;
        end
        r.data = v[7:0];
        return r;
    endfunction

    task automatic send(input logic [23:0] acc, input logic [4:0] sh);
        int n = 0;
        bit accepted = 1'b0;
        i_valid    = 1'b1;
        i_acc_data = acc;
        i_shift    = sh;
        while (!accepted && n < 200) begin
            #3;
            if (o_ready) begin
                exp_q.push_back(model(acc, sh));
                acc_cyc_q.push_back(cyc);
                accepted = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        i_valid    = 1'b0;
        i_acc_data = 24'($urandom);
        i_shift    = 5'($urandom);
        if (!accepted) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        i_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: samples 3 time units after each falling edge, well before the rising edge.
    initial begin
        int   model_cnt;
        int   model_cnt4;
        bit   prev_stall;
        bit   sat_x;
        logic [7:0] held;
        exp_t e;
        int   ac;
        model_cnt = 0; model_cnt4 = 0; prev_stall = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                model_cnt = 0; model_cnt4 = 0; prev_stall = 1'b0;
            end else begin
                chk("sat_cnt", o_sat_cnt, model_cnt);
                chk("sat_cnt4", o_sat_cnt4, model_cnt4);
                if (prev_stall) begin
                    chk("stall_valid", o_valid, 1);
                    chk("stall_hold", o_bound_data, held);
                end
                sat_x = 1'b0;
                if (o_valid && i_ready) begin
                    chk("valid4", o_valid4, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", o_bound_data, -1);
                    end else begin
                        e  = exp_q.pop_front();
                        ac = acc_cyc_q.pop_front();
                        chk("data", o_bound_data, e.data);
                        chk("data4", o_bound_data4, e.data);
                        if (lat_chk) chk("latency", cyc - ac, 2);
                        sat_x = e.sat;
                    end
                end
                if (i_sat_clr) begin
                    model_cnt = 0; model_cnt4 = 0;
                end else if (sat_x) begin
                    if (model_cnt < 65535) model_cnt++;
                    if (model_cnt4 < 15) model_cnt4++;
                end
                prev_stall = o_valid && !i_ready;
                held       = o_bound_data;
            end
        end
    end

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sat_clr = 1'b0;
        i_acc_data = '0; i_shift = '0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_bound_data, 0);
        chk("rst_cnt", o_sat_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("rst_ready", o_ready, 1);
        @(negedge clk);

        // Passthrough and rounding, back-to-back with exact 2-cycle latency
        lat_chk = 1'b1;
        send(24'd100, 5'd0);
        send(-24'sd5, 5'd0);
        send(24'd296, 5'd4);
        send(-24'sd24, 5'd4);
        send(-24'sd3, 5'd1);
        send(24'h400000, 5'd31);
        drain();
        lat_chk = 1'b0;

        // Saturation: three saturating words from a cleared counter
        i_sat_clr = 1'b1; @(negedge clk); i_sat_clr = 1'b0;
        send(24'h7FFFFF, 5'd0);
        send(24'h800000, 5'd0);
        send(24'h7FFFFF, 5'd1);
        drain();
        #3; chk("sat_cnt_3", o_sat_cnt, 3);
        @(negedge clk);

        // Backpressure: 3-cycle stall mid-stream
        fork
            begin
                for (int k = 1; k <= 6; k++) send(24'(k), 5'd0);
            end
            begin
                repeat (2) @(negedge clk);
                i_ready = 1'b0;
                repeat (2) @(negedge clk);
                #3;
                chk("bp_ready_low", o_ready, 0);
                chk("bp_ready_low4", o_ready4, 0);
                @(negedge clk);
                i_ready = 1'b1;
            end
        join
        drain();

        // Clear in the same cycle as a saturated output transfer
        i_ready = 1'b0;
        send(24'h7FFFFF, 5'd0);
        @(negedge clk);
        i_ready = 1'b1; i_sat_clr = 1'b1;
        @(negedge clk);
        i_sat_clr = 1'b0;
        #3; chk("clr_priority", o_sat_cnt, 0);
        @(negedge clk);
        drain();

        // Sticky counter: 20 saturating words into the 4-bit instance
        for (int k = 0; k < 20; k++) send((k % 2 == 0) ? 24'h7FFFFF : 24'h800000, 5'd0);
        drain();
        #3;
        chk("sticky_cnt4", o_sat_cnt4, 15);
        chk("cnt16_20", o_sat_cnt, 20);
        @(negedge clk);

        // Randomised traffic with random backpressure and occasional clears
        fork
            begin
                logic [23:0] a;
                for (int k = 0; k < 150; k++) begin
                    a = 24'($urandom);
                    if ($urandom_range(0, 1) == 1) a = 24'($signed(12'($urandom)));
                    send(a, 5'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    i_ready   = ($urandom_range(0, 3) != 0);
                    i_sat_clr = ($urandom_range(0, 15) == 0);
                end
                i_sat_clr = 1'b0;
            end
        join
        drain();

        // Reset with both stages full: nothing stale may emerge afterwards
        i_ready = 1'b0;
        send(24'd5, 5'd0);
        send(24'd6, 5'd0);
        #3;
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_ready", o_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        #3;
        exp_q.delete();
        acc_cyc_q.delete();
        @(negedge clk);
        reset = 1'b0; i_ready = 1'b1;
        #3;
        chk("post_rst_valid", o_valid, 0);
        chk("post_rst_ready", o_ready, 1);
        chk("post_rst_ready4", o_ready4, 1);
        chk("post_rst_cnt", o_sat_cnt, 0);
        chk("post_rst_data", o_bound_data, 0);
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bound_requant.md
Name: bound_requant

Overview:
Requantization/bound stage that sits directly upstream of the ReLU activation block.
- Takes a wide signed accumulator word from the MAC array.
- Applies a rounding arithmetic right shift, then saturates to a signed BO_BW word (i_bound_data of ReLU).
- Two-stage pipeline with valid/ready handshakes on both sides.
- Counts saturation events for the host.

Parameters:
ACC_BW, 24, signed accumulator input width
BO_BW, 8, signed bounded output width (matches ReLU BO_BW)
SH_BW, 5, shift-amount width
CNT_BW, 16, saturation counter width

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  synchronous active-high reset
i_valid  input  1  upstream data valid
o_ready  output  1  block can accept input this cycle
i_acc_data  input  ACC_BW  signed accumulator value
i_shift  input  SH_BW  right-shift amount, sampled with i_acc_data
o_valid  output  1  o_bound_data valid
i_ready  input  1  downstream accepts this cycle
o_bound_data  output  BO_BW  signed saturated result
o_sat_cnt  output  CNT_BW  count of saturated outputs delivered
i_sat_clr  input  1  clears o_sat_cnt

Behaviour:
- Reset (synchronous, active-high): both stage valids 0; o_valid=0; o_bound_data=0; o_sat_cnt=0; o_ready=1 on the cycle after reset.
- Handshake: input transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
- Pipeline enables:
  - en2 = !o_valid || i_ready
  - en1 = !s1_valid || en2
  - o_ready = en1 (combinational from i_ready; no skid buffer)
- Latency and throughput: 2 cycles input-to-output with i_ready held high; 1 word/cycle sustained.
- Stall: while o_valid && !i_ready, o_bound_data and o_valid hold stable. Stage 1 still fills if it is empty. No word is dropped or duplicated. Order is preserved.
- Stage 1 (round-shift):
  - Clamp: sh = min(i_shift, ACC_BW-1).
  - sh==0: pass value unchanged.
  - Otherwise: sign-extend to ACC_BW+1 bits, add 2^(sh-1), arithmetic shift right by sh. This is round-half-toward-+inf.
  - The ACC_BW+1 width prevents overflow on the rounding add.
  - Register the result in s1_data.
- Stage 2 (saturate):
  - s1_data > 2^(BO_BW-1)-1 -> output 2^(BO_BW-1)-1, sat=1.
  - s1_data < -2^(BO_BW-1) -> output -2^(BO_BW-1), sat=1.
  - Otherwise: truncate to BO_BW bits, sat=0.
  - Register data and sat flag.
- Counter:
  - Increments on an output transfer whose sat flag is set.
  - Sticks at all-ones; does not wrap.
  - i_sat_clr sets it to 0 next cycle. Clear has priority over a same-cycle increment.
  - Counter is independent of stalls.
- Reset mid-stream: all in-flight words are discarded; no output transfer follows reset.
- Undefined i_acc_data is tolerated when i_valid=0; data registers load only on their stage enable with valid.

Decomposition:
- Shared package (quant_pkg): default ACC_BW/BO_BW/SH_BW/CNT_BW, plus localparams BO_MAX and BO_MIN derived from BO_BW. ReLU and this block share the BO_BW value from the package.
- One sub-module: bound_round_shift, the combinational clamp/round/shift for stage 1, instantiated once. Saturation and handshake logic stay in the top module.

Test Plan:
- Passthrough, shift=0, i_ready=1: acc 100 -> 0x64; acc -5 -> 0xFB. o_valid rises exactly 2 cycles after each input transfer; back-to-back inputs give back-to-back outputs.
- Rounding: shift=4, acc 296 -> 19 (0x13); acc -24 -> -1 (0xFF). Shift=1, acc -3 -> -1 (0xFF). Shift=31 with ACC_BW=24 behaves as shift=23: acc 0x400000 -> 1.
- Saturation:
  - shift=0: acc 0x7FFFFF -> 0x7F; acc 0x800000 -> 0x80.
  - shift=1: acc 0x7FFFFF -> 0x7F (no add overflow).
  - o_sat_cnt = 3 after these three outputs are accepted.
- Backpressure: stream 6 words (1..6, shift=0) and drop i_ready for 3 cycles mid-stream. o_ready goes low once both stages are full; o_bound_data holds stable while stalled; output sequence is exactly 1..6.
- Counter edges:
  - i_sat_clr in the same cycle as a saturated output transfer -> count 0.
  - Force CNT_BW=4 and feed 20 saturating words -> count sticks at 0xF.
- Reset mid-stream: assert reset with both stages valid. Next cycle o_valid=0, o_ready=1, o_sat_cnt=0; no stale word appears after reset is released.
